// File: rtl/timer_pkg.sv
// Shared types and digit limits for the mm:ss countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } tstate_t;

  localparam int SEC_TENS_MAX = 5;
  localparam int ONES_MAX     = 9;
  localparam int ALARM_CNT_W  = 6;

endpackage

// File: rtl/cnt60_updn.sv
// One mod-60 BCD digit pair (tens 0-5, ones 0-9) with increment, decrement and borrow out.
module cnt60_updn
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clr,
  input  logic       inc,
  input  logic       dec,
  output logic [2:0] tens,
  output logic [3:0] ones,
  output logic       bo
);

  logic at_zero;

  assign at_zero = (tens == 3'd0) && (ones == 4'd0);
  // Borrow is combinational so the next pair down-chain decrements in the same edge.
  assign bo = dec && at_zero;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!n_rst || clr) begin
      tens <= 3'd0;
      ones <= 4'd0;
    end else if (dec) begin
      if (ones == 4'd0) begin
        ones <= 4'(ONES_MAX);
        tens <= (tens == 3'd0) ? 3'(SEC_TENS_MAX) : tens - 3'd1;
      end else begin
        ones <= ones - 4'd1;
      end
    end else if (inc) begin
      if (ones == 4'(ONES_MAX)) begin
        ones <= 4'd0;
        tens <= (tens == 3'(SEC_TENS_MAX)) ? 3'd0 : tens + 3'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/cnt_down_timer.sv
// Kitchen-style mm:ss countdown timer: set with secup/minup, start/pause, alarm at 00:00.
module cnt_down_timer
  import timer_pkg::*;
#(
  parameter int ALARM_SEC = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       en1hz,
  input  logic       secup,
  input  logic       minup,
  input  logic       start,
  input  logic       clr,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic       running,
  output logic       alarm
);

  tstate_t                state, state_nxt, state_fix;
  logic [ALARM_CNT_W-1:0] acnt, acnt_nxt;
  logic sec_inc, sec_dec, min_inc, sec_bo, min_bo;
  logic val_clr, val_clr_all, is_zero, one_left;

  assign is_zero  = (min_tens == 3'd0) && (min_ones == 4'd0) &&
                    (sec_tens == 3'd0) && (sec_ones == 4'd0);
  assign one_left = (min_tens == 3'd0) && (min_ones == 4'd0) &&
                    (sec_tens == 3'd0) && (sec_ones == 4'd1);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_nxt = state;
    acnt_nxt  = '0;
    sec_inc   = 1'b0;
    sec_dec   = 1'b0;
    min_inc   = 1'b0;
    val_clr   = 1'b0;
    if (clr) begin
      state_nxt = IDLE;
      val_clr   = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          sec_inc = secup;
          min_inc = minup;
          if (start && !is_zero) state_nxt = RUN;
        end
        RUN: begin
          sec_dec = en1hz;
          if (en1hz && one_left) state_nxt = ALARM;
          else if (start)        state_nxt = PAUSE;
        end
        PAUSE: begin
          if (start) state_nxt = RUN;
        end
        ALARM: begin
          acnt_nxt = acnt;
          if (start) begin
            state_nxt = IDLE;
          end else if (en1hz) begin
            if (acnt == ALARM_CNT_W'(ALARM_SEC - 1)) state_nxt = IDLE;
            else acnt_nxt = acnt + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A minutes borrow means 00:00 underflowed; recover to a clean IDLE rather than show 59:59.
  assign state_fix   = min_bo ? IDLE : state_nxt;
  assign val_clr_all = val_clr || min_bo;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
      acnt  <= '0;
    end else begin
      state <= state_fix;
      acnt  <= (state_fix == ALARM) ? acnt_nxt : '0;
    end
  end

  cnt60_updn u_sec (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (val_clr_all),
    .inc   (sec_inc),
    .dec   (sec_dec),
    .tens  (sec_tens),
    .ones  (sec_ones),
    .bo    (sec_bo)
  );

  cnt60_updn u_min (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (val_clr_all),
    .inc   (min_inc),
    .dec   (sec_bo),
    .tens  (min_tens),
    .ones  (min_ones),
    .bo    (min_bo)
  );

  assign running = (state == RUN);
  assign alarm   = (state == ALARM);

endmodule

// File: tb/tb_cnt_down_timer.sv
// Directed-vector scoreboard bench for cnt_down_timer; a monitor pops expected outputs.
module tb_cnt_down_timer;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       en1hz = 1'b0, secup = 1'b0, minup = 1'b0, start = 1'b0, clr = 1'b0;
  logic [3:0] sec_ones, min_ones;
  logic [2:0] sec_tens, min_tens;
  logic       running, alarm;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   stim_done = 1'b0;

  cnt_down_timer #(.ALARM_SEC(10)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .en1hz    (en1hz),
    .secup    (secup),
    .minup    (minup),
    .start    (start),
    .clr      (clr),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens),
    .running  (running),
    .alarm    (alarm)
  );

  always #5 clk = ~clk;

  // Packed view: {min_tens, min_ones, sec_tens, sec_ones, running, alarm}
  function automatic logic [15:0] ev(input int mm, input int ss, input bit r, input bit a);
    return {3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10), r, a};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got mm:ss=%0d%0d:%0d%0d run=%0b alm=%0b, want %0d%0d:%0d%0d run=%0b alm=%0b",
               name, act[15:13], act[12:9], act[8:6], act[5:2], act[1], act[0],
               exp[15:13], exp[12:9], exp[8:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // One clock of stimulus; optionally queue the expected outputs after that edge.
  task automatic step(input bit s_up, input bit m_up, input bit st, input bit cl, input bit en,
                      input bit chk, input logic [15:0] exp, input string name);
    @(negedge clk);
    secup = s_up; minup = m_up; start = st; clr = cl; en1hz = en;
    @(posedge clk);
    #1;
    secup = 1'b0; minup = 1'b0; start = 1'b0; clr = 1'b0; en1hz = 1'b0;
    if (chk) exp_q.push_back('{name, exp});
  endtask

  task automatic reset_pulse(input bit en, input bit st, input string name);
    @(negedge clk);
    n_rst = 1'b0; en1hz = en; start = st;
    @(posedge clk);
    #1;
    n_rst = 1'b1; en1hz = 1'b0; start = 1'b0;
    exp_q.push_back('{name, ev(0, 0, 0, 0)});
  endtask

  task automatic n_sec(input int n);
    repeat (n) step(1, 0, 0, 0, 0, 0, '0, "");
  endtask
  task automatic n_min(input int n);
    repeat (n) step(0, 1, 0, 0, 0, 0, '0, "");
  endtask
  task automatic n_en(input int n);
    repeat (n) step(0, 0, 0, 0, 1, 0, '0, "");
  endtask

  // Monitor: outputs are stable at the falling edge following the causing rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, {min_tens, min_ones, sec_tens, sec_ones, running, alarm}, e.exp);
      end
    end
  end

  initial begin
    reset_pulse(0, 0, "reset");

    // Setting and start
    n_min(3);
    n_sec(4);
    step(1, 0, 0, 0, 0, 1, ev(3, 5, 0, 0), "set_03_05");
    step(0, 0, 1, 0, 0, 1, ev(3, 5, 1, 0), "start_run");
    step(0, 1, 0, 0, 0, 1, ev(3, 5, 1, 0), "minup_ign_run");
    step(0, 0, 0, 1, 0, 1, ev(0, 0, 0, 0), "clr_in_run");

    // 01:00 countdown to alarm
    n_min(1);
    step(0, 0, 1, 0, 0, 0, '0, "");
    step(0, 0, 0, 0, 1, 1, ev(0, 59, 1, 0), "borrow_00_59");
    n_en(57);
    step(0, 0, 0, 0, 1, 1, ev(0, 1, 1, 0), "run_00_01");
    step(0, 0, 0, 0, 1, 1, ev(0, 0, 0, 1), "reach_alarm");

    // Alarm duration and start-abort
    n_en(9);
    step(1, 1, 0, 0, 0, 1, ev(0, 0, 0, 1), "alarm_after_9");
    step(0, 0, 0, 0, 1, 1, ev(0, 0, 0, 0), "alarm_timeout");
    step(1, 0, 0, 0, 0, 0, '0, "");
    step(0, 0, 1, 0, 0, 0, '0, "");
    step(0, 0, 0, 0, 1, 1, ev(0, 0, 0, 1), "alarm_again");
    step(0, 0, 1, 0, 1, 1, ev(0, 0, 0, 0), "alarm_start_abort");

    // Pause behaviour
    n_sec(5);
    step(0, 0, 1, 0, 0, 0, '0, "");
    step(0, 0, 1, 0, 1, 1, ev(0, 4, 0, 0), "start_en_pause");
    n_en(19);
    step(0, 0, 0, 0, 1, 1, ev(0, 4, 0, 0), "pause_frozen");
    step(1, 1, 0, 0, 0, 1, ev(0, 4, 0, 0), "pause_set_ign");
    step(0, 0, 1, 0, 0, 1, ev(0, 4, 1, 0), "resume");
    step(0, 0, 0, 0, 1, 1, ev(0, 3, 1, 0), "resume_dec");
    step(0, 0, 1, 0, 0, 0, '0, "");
    step(0, 0, 0, 1, 0, 1, ev(0, 0, 0, 0), "clr_in_pause");

    // Zero start and wraps
    step(0, 0, 1, 0, 0, 1, ev(0, 0, 0, 0), "start_at_zero");
    n_sec(58);
    step(1, 0, 0, 0, 0, 1, ev(0, 59, 0, 0), "sec_59");
    step(1, 0, 0, 0, 0, 1, ev(0, 0, 0, 0), "sec_wrap_nocarry");
    step(1, 1, 0, 0, 0, 1, ev(1, 1, 0, 0), "sec_min_both");
    n_min(57);
    step(0, 1, 0, 0, 0, 1, ev(59, 1, 0, 0), "min_59");
    step(0, 1, 0, 0, 0, 1, ev(0, 1, 0, 0), "min_wrap");
    step(0, 0, 0, 1, 0, 0, '0, "");

    // Borrow through the minutes tens digit
    n_min(10);
    step(0, 0, 1, 0, 0, 0, '0, "");
    step(0, 0, 0, 0, 1, 1, ev(9, 59, 1, 0), "borrow_10_00");
    step(0, 0, 0, 1, 0, 0, '0, "");

    // Reset mid-run, then clr beating minup
    n_min(12);
    n_sec(33);
    step(1, 0, 0, 0, 0, 1, ev(12, 34, 0, 0), "set_12_34");
    step(0, 0, 1, 0, 0, 0, '0, "");
    reset_pulse(1, 1, "reset_mid_run");
    n_min(5);
    step(0, 1, 0, 1, 0, 1, ev(0, 0, 0, 0), "clr_beats_minup");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cnt_down_timer.md
Name: cnt_down_timer

Overview:
Minute:second countdown timer (kitchen-timer style), the down-counting counterpart of the min:sec clock path.
- Consumes single-cycle button pulses from btn_in and the 1 Hz enable from cnt1sec.
- Holds an mm:ss BCD value, decrements it once per second while running, and raises an alarm at 00:00.
- Digit outputs feed the existing 7-segment decoders directly.

Parameters:
ALARM_SEC, 10, number of en1hz pulses the alarm stays asserted before auto-return to IDLE (1..63)

Ports:
clk  input  1  system clock
n_rst  input  1  reset, synchronous, active-low
en1hz  input  1  one-cycle strobe at 1 Hz
secup  input  1  one-cycle pulse: increment seconds while setting
minup  input  1  one-cycle pulse: increment minutes while setting
start  input  1  one-cycle pulse: start/pause toggle
clr  input  1  one-cycle pulse: abort and clear to 00:00
sec_ones  output  4  seconds ones digit, BCD 0-9
sec_tens  output  3  seconds tens digit, 0-5
min_ones  output  4  minutes ones digit, BCD 0-9
min_tens  output  3  minutes tens digit, 0-5
running  output  1  high in RUN state
alarm  output  1  high in ALARM state

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous, active-low, on n_rst, sampled at the clk rising edge.
- Reset values: all digits 0, state IDLE, running=0, alarm=0, alarm counter 0.
- Registered outputs: every output changes on the clk edge after the causing input; latency 1 cycle.
- States: IDLE, RUN, PAUSE, ALARM. running = (state==RUN). alarm = (state==ALARM).
- Priority: clr beats every other input in every state. clr means next state IDLE and value 00:00.
- IDLE:
  - secup: seconds +1, 59 wraps to 00 with no carry into minutes.
  - minup: minutes +1, 59 wraps to 00.
  - secup and minup in the same cycle: both apply.
  - start with value != 00:00: go to RUN. start at 00:00: ignored.
  - en1hz: ignored.
- RUN:
  - en1hz: value -1 s. Seconds 00 borrows to 59 and minutes -1.
  - If the decrement produces 00:00, go to ALARM in the same update.
  - start: go to PAUSE. If start and en1hz coincide, the decrement applies and the state goes to PAUSE. ALARM wins if the decrement reaches 00:00.
  - secup/minup: ignored.
- PAUSE:
  - Value frozen; en1hz, secup and minup ignored.
  - start: go to RUN.
- ALARM:
  - Value held at 00:00. Alarm counter cleared on entry.
  - Each en1hz increments the counter. When the counter reaches ALARM_SEC, go to IDLE.
  - start or clr: go to IDLE immediately.
  - secup/minup: ignored.
- Reset mid-operation: on any cycle with n_rst=0, all state returns to reset values, whatever the inputs.
- Digit invariants: sec_tens and min_tens never exceed 5; sec_ones and min_ones never exceed 9; no illegal BCD ever appears on the outputs.
- Decrement from 00:00 is unreachable: RUN is only entered with a nonzero value and leaves at 00:00.

Decomposition:
- Package timer_pkg holds:
  - state typedef tstate_t {IDLE, RUN, PAUSE, ALARM};
  - digit limit constants SEC_TENS_MAX=5, ONES_MAX=9;
  - localparam ALARM_CNT_W=6.
- Sub-module cnt60_updn: one mod-60 BCD digit pair with inputs INC and DEC and outputs tens/ones plus borrow BO.
  - BO pulses when DEC is applied at 00.
  - One instance for seconds, one for minutes; the seconds BO drives the minutes DEC.
  - INC never carries into the minutes instance.
- Top module holds the FSM, the zero detect and the alarm counter.

Test Plan:
- Reset, then 3 minup and 5 secup pulses -> digits read 03:05, running=0, alarm=0; start -> running=1 on the next cycle.
- From 01:00, RUN, one en1hz -> 00:59 next cycle; a further 59 en1hz -> 00:00 with alarm=1 and running=0 in the same update.
- ALARM with ALARM_SEC=10 -> alarm stays 1 for exactly 10 en1hz pulses, then IDLE; a repeat run with a start pulse during ALARM -> IDLE the next cycle.
- 00:05 RUN, start and en1hz in the same cycle -> 00:04 with state PAUSE; 20 en1hz pulses -> still 00:04; start -> RUN.
- IDLE at 00:00, start -> no state change; 59 secup pulses then 1 more -> 00:59, then 00:00 with minutes unchanged.
- 12:34 RUN, n_rst=0 for one cycle coinciding with en1hz and start -> 00:00, IDLE, all flags 0; clr with minup in IDLE at 05:00 -> 00:00.
